// File: rtl/sha1_pkg.sv
// Shared definitions for the SHA-1 message padder and core: FSM encodings,
// block geometry and the SHA-1 initial hash value / round constants.
package sha1_pkg;

  typedef enum logic [2:0] {
    ST_ACCEPT = 3'd0,
    ST_EMIT   = 3'd1,
    ST_PAD    = 3'd2,
    ST_PAD2   = 3'd3,
    ST_DROP   = 3'd4
  } state_t;

  localparam int BLOCK_W = 512;
  localparam int BLOCK_BYTES = BLOCK_W / 8;
  // byte position of the 64-bit length field inside a block
  localparam int LEN_OFF = 56;

  // H0..H4, H0 in the most significant word
  localparam logic [159:0] SHA1_IV = {
    32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0
  };

  // round constants for rounds 0-19, 20-39, 40-59, 60-79 (first in MS word)
  localparam logic [127:0] SHA1_K = {
    32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hCA62C1D6
  };

  // bit offset of the LSB of message byte k within a big-endian block
  function automatic logic [8:0] byte_lsb(input logic [5:0] k);
    return {~k, 3'b000};
  endfunction

endpackage

// File: rtl/sha1_pad_mask.sv
// Byte-lane insert generator for the padding step. For a PAD cycle it keeps
// bytes below ptr, places 0x80 at ptr, zeros the rest and, when the length
// field still fits, drops the bit length into bytes 56..63. For a PAD2 cycle
// only the length field survives.
module sha1_pad_mask
  import sha1_pkg::*;
(
  input  logic [5:0]         ptr,
  input  logic               pad2,
  input  logic [63:0]        bit_len,
  output logic [BLOCK_W-1:0] keep,
  output logic [BLOCK_W-1:0] ins,
  output logic               fits
);

  // per-lane keep mask and insert value
  always_comb begin
    keep = '0;
    ins  = '0;
    fits = pad2 || (ptr < 6'(LEN_OFF));
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (!pad2) begin
        if (k < int'(ptr)) begin
          keep[BLOCK_W-1-8*k -: 8] = 8'hFF;
        end else if (k == int'(ptr)) begin
          ins[BLOCK_W-1-8*k -: 8] = 8'h80;
        end
      end
    end
    if (fits) begin
      ins[63:0] = bit_len;
    end
  end

endmodule

// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs a byte stream into 512-bit big-endian blocks,
// appends 0x80, zero fill and the 64-bit bit length.
// Build option: SHA1_PAD_MULTI_BLOCK_EN allows messages of any number of
// blocks; without it messages are limited to 55 bytes (one block) and a
// longer message raises err and is dropped.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ACCEPT | taking message bytes into the buffer at ptr
// EMIT   | block offered on block/block_valid until block_ready
// PAD    | one cycle: 0x80, zero fill, length if it fits
// PAD2   | one cycle: extra block holding only the length field
// DROP   | overlong message, bytes swallowed up to in_last
module sha1_pad
  import sha1_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] block,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_last,
  output logic               err
);

  state_t             state;
  state_t             emit_next;
  logic [6:0]         ptr;
  logic [63:0]        bit_len;
  logic [BLOCK_W-1:0] blk_q;
  logic [BLOCK_W-1:0] pad_keep;
  logic [BLOCK_W-1:0] pad_ins;
  logic               pad_fits;
  logic               overflow;

  sha1_pad_mask u_mask (
    .ptr     (ptr[5:0]),
    .pad2    (state == ST_PAD2),
    .bit_len (bit_len),
    .keep    (pad_keep),
    .ins     (pad_ins),
    .fits    (pad_fits)
  );

`ifdef SHA1_PAD_MULTI_BLOCK_EN
  // 2^61-1 bytes already counted: one more would wrap the bit length
  assign overflow = (bit_len == 64'hFFFF_FFFF_FFFF_FFF8);
`else
  // single-block build: the 56th byte leaves no room for the length field
  assign overflow = (ptr == 7'(LEN_OFF - 1));
`endif

  assign in_ready    = (state == ST_ACCEPT) || (state == ST_DROP);
  assign block_valid = (state == ST_EMIT);
  assign block       = blk_q;

  // padder FSM with buffer, pointer and length datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_ACCEPT;
      emit_next  <= ST_ACCEPT;
      ptr        <= '0;
      bit_len    <= '0;
      blk_q      <= '0;
      block_last <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_ACCEPT: begin
          if (in_valid) begin
            if (overflow) begin
              err     <= 1'b1;
              blk_q   <= '0;
              ptr     <= '0;
              bit_len <= '0;
              state   <= in_last ? ST_ACCEPT : ST_DROP;
            end else begin
              blk_q[byte_lsb(ptr[5:0]) +: 8] <= in_data;
              ptr     <= ptr + 7'd1;
              bit_len <= bit_len + 64'd8;
              if (ptr == 7'(BLOCK_BYTES - 1)) begin
                // full block goes out first; padding restarts at ptr 0
                state      <= ST_EMIT;
                emit_next  <= in_last ? ST_PAD : ST_ACCEPT;
                block_last <= 1'b0;
              end else if (in_last) begin
                state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          blk_q      <= (blk_q & pad_keep) | pad_ins;
          block_last <= pad_fits;
          emit_next  <= pad_fits ? ST_ACCEPT : ST_PAD2;
          state      <= ST_EMIT;
        end
        ST_PAD2: begin
          blk_q      <= pad_ins;
          block_last <= 1'b1;
          emit_next  <= ST_ACCEPT;
          state      <= ST_EMIT;
        end
        ST_EMIT: begin
          if (block_ready) begin
            blk_q <= '0;
            ptr   <= '0;
            if (block_last) begin
              bit_len <= '0;
            end
            block_last <= 1'b0;
            state      <= emit_next;
          end
        end
        ST_DROP: begin
          if (in_valid && in_last) begin
            state <= ST_ACCEPT;
          end
        end
        default: state <= ST_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_pad.sv
// Self-checking bench for sha1_pad. Expected blocks come from a byte-level
// padding model (append 0x80, zero fill to 56 mod 64, 64-bit bit length,
// split into 64-byte chunks). Inputs change 1 time unit after the rising
// edge; outputs and handshakes are observed on the falling edge.
module tb_sha1_pad;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [511:0] block;
  logic         block_valid;
  logic         block_ready = 1'b0;
  logic         block_last;
  logic         err;

  sha1_pad dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .block       (block),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [512:0] got_q[$];
  logic [512:0] exp_q[$];
  logic [7:0]   msg[$];
  int           rd_idx = 0;
  int           err_cnt = 0;
  bit           rdy_auto = 1'b0;
  logic         rdy_force = 1'b0;

  // consumer: random or forced block_ready
  always @(posedge clk) begin
    #1;
    block_ready = rdy_auto ? ($urandom_range(0, 2) != 0) : rdy_force;
  end

  // monitor: record handshaken blocks and err pulses
  always @(negedge clk) begin
    if (reset) begin
      if (block_valid && block_ready) got_q.push_back({block_last, block});
      if (err) err_cnt++;
    end
  end

  function automatic bit model_msg();
    logic [7:0]   p[$];
    logic [63:0]  bl;
    logic [511:0] b;
    logic         lst;
    int           nb;
    int           n;
    n = msg.size();
`ifndef SHA1_PAD_MULTI_BLOCK_EN
    if (n > 55) return 1'b1;
`endif
    foreach (msg[i]) p.push_back(msg[i]);
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    bl = 64'(n) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*bi+j];
      lst = (bi == nb - 1);
      exp_q.push_back({lst, b});
    end
    return 1'b0;
  endfunction

  task automatic make_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic make_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  task automatic send(input bit gaps, input bit do_last, output bit ok);
    int i = 0;
    int guard = 0;
    while (i < msg.size() && guard < 5000) begin
      @(posedge clk); #1;
      in_valid = !(gaps && ($urandom_range(0, 3) == 0));
      in_data  = msg[i];
      in_last  = do_last && (i == msg.size() - 1);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    ok = (i == msg.size());
  endtask

  task automatic wait_blocks(output bit ok);
    int g = 0;
    while (got_q.size() < exp_q.size() && g < 4000) begin
      @(negedge clk);
      g++;
    end
    ok = (got_q.size() >= exp_q.size());
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    int g = 0;
    while (!block_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    ok = block_valid;
  endtask

  task automatic resync();
    while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    while (exp_q.size() < got_q.size()) exp_q.push_back(got_q[exp_q.size()]);
    rd_idx = got_q.size();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (block_valid !== 1'b0) begin errors++; $display("FAIL reset_block_valid: got %b want 0", block_valid); end
    checks++;
    if (block_last !== 1'b0) begin errors++; $display("FAIL reset_block_last: got %b want 0", block_last); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++;
    if (block !== 512'h0) begin errors++; $display("FAIL reset_block: got %h want 0", block); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (block_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", block_valid); end
  endtask

  task automatic test_abc();
    bit ok;
    bit e;
    make_abc();
    e = model_msg();
    rdy_auto = 1'b1;
    send(1'b1, 1'b1, ok);
    checks++;
    if (!ok || e) begin errors++; $display("FAIL abc_send: sent_ok %b want 1", ok); end
    wait_blocks(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abc_timeout: got %0d blocks want %0d", got_q.size(), exp_q.size()); end
    if (rd_idx < got_q.size()) begin
      checks++;
      if (got_q[rd_idx] !== {1'b1, 32'h61626380, 416'h0, 64'h18}) begin
        errors++;
        $display("FAIL abc_const: got last=%b %h want last=1 61626380..18", got_q[rd_idx][512], got_q[rd_idx][511:0]);
      end
    end
    while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
      checks++;
      if (got_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL abc_block[%0d]: got last=%b %h want last=%b %h", rd_idx, got_q[rd_idx][512], got_q[rd_idx][511:0], exp_q[rd_idx][512], exp_q[rd_idx][511:0]);
      end
      rd_idx++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abc_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    resync();
  endtask

  task automatic test_55_zeros();
    bit ok;
    bit e;
    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'h00);
    e = model_msg();
    rdy_auto = 1'b1;
    send(1'b0, 1'b1, ok);
    wait_blocks(ok);
    checks++;
    if (!ok || e) begin errors++; $display("FAIL z55_timeout: got %0d blocks want %0d", got_q.size(), exp_q.size()); end
    if (rd_idx < got_q.size()) begin
      checks++;
      if (got_q[rd_idx] !== {1'b1, 440'h0, 8'h80, 64'h1B8}) begin
        errors++;
        $display("FAIL z55_const: got last=%b %h want last=1 byte55=80 len=1b8", got_q[rd_idx][512], got_q[rd_idx][511:0]);
      end
    end
    while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
      checks++;
      if (got_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL z55_block[%0d]: got last=%b %h want last=%b %h", rd_idx, got_q[rd_idx][512], got_q[rd_idx][511:0], exp_q[rd_idx][512], exp_q[rd_idx][511:0]);
      end
      rd_idx++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL z55_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    resync();
  endtask

  task automatic test_stall();
    bit ok;
    bit e;
    logic [511:0] snap_b;
    logic         snap_l;
`ifdef SHA1_PAD_MULTI_BLOCK_EN
    make_msg(64);
`else
    make_msg($urandom_range(1, 55));
`endif
    e = model_msg();
    rdy_auto  = 1'b0;
    rdy_force = 1'b0;
    send(1'b1, 1'b1, ok);
    wait_valid(ok);
    checks++;
    if (!ok || e) begin errors++; $display("FAIL stall_valid_timeout: got %b want 1", block_valid); end
    snap_b = block;
    snap_l = block_last;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (block_valid !== 1'b1 || block !== snap_b || block_last !== snap_l || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b in_ready=%b last=%b want valid=1 in_ready=0 last=%b stable", c, block_valid, in_ready, block_last, snap_l);
      end
    end
    rdy_auto = 1'b1;
    wait_blocks(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d blocks want %0d", got_q.size(), exp_q.size()); end
    while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
      checks++;
      if (got_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL stall_block[%0d]: got last=%b %h want last=%b %h", rd_idx, got_q[rd_idx][512], got_q[rd_idx][511:0], exp_q[rd_idx][512], exp_q[rd_idx][511:0]);
      end
      rd_idx++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    resync();
  endtask

`ifndef SHA1_PAD_MULTI_BLOCK_EN
  task automatic test_overflow();
    bit ok;
    bit e;
    int eb;
    int nb;
    eb = err_cnt;
    nb = got_q.size();
    make_msg(60);
    e = model_msg();
    rdy_auto = 1'b1;
    send(1'b1, 1'b1, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || !e) begin errors++; $display("FAIL ovf_send: sent_ok %b model_err %b want 1 1", ok, e); end
    checks++;
    if (err_cnt - eb != 1) begin errors++; $display("FAIL ovf_err_pulses: got %0d want 1", err_cnt - eb); end
    checks++;
    if (got_q.size() != nb) begin errors++; $display("FAIL ovf_no_block: got %0d blocks want 0", got_q.size() - nb); end
    resync();
  endtask
`else
  task automatic test_multi_56();
    bit ok;
    bit e;
    make_msg(56);
    e = model_msg();
    rdy_auto = 1'b1;
    send(1'b1, 1'b1, ok);
    wait_blocks(ok);
    checks++;
    if (!ok || e) begin errors++; $display("FAIL m56_timeout: got %0d blocks want %0d", got_q.size(), exp_q.size()); end
    if (rd_idx + 1 < got_q.size()) begin
      checks++;
      if (got_q[rd_idx+1] !== {1'b1, 448'h0, 64'h1C0}) begin
        errors++;
        $display("FAIL m56_len_block: got last=%b %h want last=1 len=1c0", got_q[rd_idx+1][512], got_q[rd_idx+1][511:0]);
      end
    end
    while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
      checks++;
      if (got_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL m56_block[%0d]: got last=%b %h want last=%b %h", rd_idx, got_q[rd_idx][512], got_q[rd_idx][511:0], exp_q[rd_idx][512], exp_q[rd_idx][511:0]);
      end
      rd_idx++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL m56_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    resync();
  endtask
`endif

  task automatic test_reset_abort();
    bit ok;
    int nb;
    int eb;
    nb = got_q.size();
    eb = err_cnt;
    rdy_auto = 1'b1;
    make_msg(30);
    send(1'b1, 1'b0, ok);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (got_q.size() != nb) begin errors++; $display("FAIL abort_msg_block: got %0d blocks want 0", got_q.size() - nb); end
    checks++;
    if (err_cnt != eb) begin errors++; $display("FAIL abort_msg_err: got %0d pulses want 0", err_cnt - eb); end
    rdy_auto  = 1'b0;
    rdy_force = 1'b0;
    make_abc();
    send(1'b0, 1'b1, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_emit_valid: got %b want 1", block_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rdy_auto = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (got_q.size() != nb || block_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_emit_block: got %0d blocks valid=%b want 0 0", got_q.size() - nb, block_valid);
    end
    resync();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit e;
    int eb;
    int exp_errs = 0;
    int n;
    eb = err_cnt;
    rdy_auto = 1'b1;
    for (int m = 0; m < 12; m++) begin
`ifdef SHA1_PAD_MULTI_BLOCK_EN
      n = $urandom_range(1, 150);
`else
      n = $urandom_range(1, 60);
`endif
      if (m == 0) n = 55;
      if (m == 1) n = 56;
      make_msg(n);
      e = model_msg();
      if (e) exp_errs++;
      send(1'b1, 1'b1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_send[%0d]: sent_ok %b want 1", m, ok); end
    end
    wait_blocks(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d blocks want %0d", got_q.size(), exp_q.size()); end
    while (rd_idx < exp_q.size() && rd_idx < got_q.size()) begin
      checks++;
      if (got_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL b2b_block[%0d]: got last=%b %h want last=%b %h", rd_idx, got_q[rd_idx][512], got_q[rd_idx][511:0], exp_q[rd_idx][512], exp_q[rd_idx][511:0]);
      end
      rd_idx++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    checks++;
    if (err_cnt - eb != exp_errs) begin errors++; $display("FAIL b2b_err_pulses: got %0d want %0d", err_cnt - eb, exp_errs); end
    resync();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_55_zeros();
    test_stall();
`ifndef SHA1_PAD_MULTI_BLOCK_EN
    test_overflow();
`else
    test_multi_56();
`endif
    test_abc();
    test_reset_abort();
    test_abc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
